gpio_pad_ctrl: RTL and testbench



---
 rtl/gpio_pad_ctrl.sv | 98 +++++++++
 tb/tb_gpio_pad_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad bank: registered IOBUF drive/tri-state plus a synchronized, optionally filtered
// input path with sticky edge-interrupt flags. Define GPIO_PAD_CTRL_FILTER_EN to enable the glitch filter.
module gpio_pad_ctrl #(
  parameter int WIDTH         = 8,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] out_value,
  input  logic [WIDTH-1:0] out_enable,
  output logic [WIDTH-1:0] pad_o,
  output logic [WIDTH-1:0] pad_t,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] in_value,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_clear,
  output logic [WIDTH-1:0] rise_pending,
  output logic [WIDTH-1:0] fall_pending,
  output logic             irq
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;

  // Reset forces every pad to high-Z at once, even if the bank was driving.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pad_o <= '0;
      pad_t <= '1;
    end else begin
      pad_o <= out_value;
      pad_t <= ~out_enable;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pad_i;
      s2 <= s1;
    end
  end

`ifdef GPIO_PAD_CTRL_FILTER_EN
  localparam int CNT_W = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CNT_W-1:0] cnt [WIDTH];

  // A new level is accepted only after FILTER_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign filt = s2;
`endif

  assign in_value = filt;
  assign rise_evt = filt & ~prev;
  assign fall_evt = ~filt & prev;

  // A new edge outranks a simultaneous clear so no event is ever lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev         <= '0;
      rise_pending <= '0;
      fall_pending <= '0;
    end else begin
      prev         <= filt;
      rise_pending <= (rise_pending & ~irq_clear) | (rise_evt & rise_en);
      fall_pending <= (fall_pending & ~irq_clear) | (fall_evt & fall_en);
    end
  end

  assign irq = |(rise_pending | fall_pending);

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Scoreboard bench for gpio_pad_ctrl: stimulus queues expected values tagged with a due cycle,
// a negedge monitor pops and compares them. Expectations follow GPIO_PAD_CTRL_FILTER_EN.
module tb_gpio_pad_ctrl;

`ifdef GPIO_PAD_CTRL_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  localparam int SEL_PO  = 0;
  localparam int SEL_PT  = 1;
  localparam int SEL_IV  = 2;
  localparam int SEL_RP  = 3;
  localparam int SEL_FP  = 4;
  localparam int SEL_IRQ = 5;

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] out_value, out_enable, pad_o, pad_t, pad_i, in_value;
  logic [7:0] rise_en, fall_en, irq_clear, rise_pending, fall_pending;
  logic       irq;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  gpio_pad_ctrl #(.WIDTH(8), .FILTER_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .out_value(out_value), .out_enable(out_enable),
    .pad_o(pad_o), .pad_t(pad_t), .pad_i(pad_i), .in_value(in_value),
    .rise_en(rise_en), .fall_en(fall_en), .irq_clear(irq_clear),
    .rise_pending(rise_pending), .fall_pending(fall_pending), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [7:0] observe(int sel);
    case (sel)
      SEL_PO:  return pad_o;
      SEL_PT:  return pad_t;
      SEL_IV:  return in_value;
      SEL_RP:  return rise_pending;
      SEL_FP:  return fall_pending;
      default: return {7'b0, irq};
    endcase
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [7:0] actual;
    actual = observe(e.sel);
    checks++;
    if (actual !== e.val) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", e.name, actual, e.val, cyc);
    end
  endtask

  task automatic expect_at(input int d, input int sel, input logic [7:0] v, input string n);
    exp_t e;
    e.due = cyc + d; e.sel = sel; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] pad, input logic [7:0] clr);
    pad_i     = pad;
    irq_clear = clr;
  endtask

  // irq_clear is always a single-cycle pulse.
  task automatic advance(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      irq_clear = '0;
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end
    end
  end

  initial begin
    reset = 1'b1; out_value = 8'hA5; out_enable = 8'hFF;
    pad_i = '0; rise_en = '0; fall_en = '0; irq_clear = '0;
    advance(2);
    expect_at(0, SEL_PT, 8'hFF, "reset pad_t");
    expect_at(0, SEL_PO, 8'h00, "reset pad_o");
    expect_at(0, SEL_IV, 8'h00, "reset in_value");
    expect_at(0, SEL_RP, 8'h00, "reset rise_pending");
    expect_at(0, SEL_FP, 8'h00, "reset fall_pending");
    expect_at(0, SEL_IRQ, 8'h00, "reset irq");
    reset = 1'b0;
    expect_at(0, SEL_PT, 8'hFF, "release pad_t before edge");
    expect_at(1, SEL_PT, 8'h00, "release pad_t");
    expect_at(1, SEL_PO, 8'hA5, "release pad_o");
    advance(3);
    reset = 1'b1;
    expect_at(0, SEL_PT, 8'hFF, "async reset pad_t");
    expect_at(0, SEL_PO, 8'h00, "async reset pad_o");
    advance(2);
    reset = 1'b0;
    advance(2);

    // Single filtered rise on pin 0, then clear.
    rise_en = 8'h01;
    applyStimulus(8'h01, 8'h00);
    expect_at(LAT - 1, SEL_IV, 8'h00, "rise0 in_value early");
    expect_at(LAT, SEL_IV, 8'h01, "rise0 in_value");
    expect_at(LAT, SEL_RP, 8'h00, "rise0 pending early");
    expect_at(LAT, SEL_IRQ, 8'h00, "rise0 irq early");
    expect_at(LAT + 1, SEL_RP, 8'h01, "rise0 pending");
    expect_at(LAT + 1, SEL_IRQ, 8'h01, "rise0 irq");
    advance(LAT + 3);
    applyStimulus(8'h01, 8'h01);
    expect_at(1, SEL_RP, 8'h00, "clear0 pending");
    expect_at(1, SEL_IRQ, 8'h00, "clear0 irq");
    advance(2);

    // Three-cycle pulse on pin 3.
    rise_en = 8'h08; fall_en = 8'h08;
    applyStimulus(8'h09, 8'h00);
`ifdef GPIO_PAD_CTRL_FILTER_EN
    expect_at(3, SEL_IV, 8'h01, "glitch in_value mid");
    expect_at(6, SEL_IV, 8'h01, "glitch in_value late");
    expect_at(10, SEL_RP, 8'h00, "glitch no rise");
    expect_at(10, SEL_FP, 8'h00, "glitch no fall");
`else
    expect_at(3, SEL_IV, 8'h09, "glitch in_value high");
    expect_at(3, SEL_RP, 8'h08, "glitch rise");
    expect_at(5, SEL_IV, 8'h01, "glitch in_value low");
    expect_at(5, SEL_FP, 8'h00, "glitch fall early");
    expect_at(6, SEL_FP, 8'h08, "glitch fall");
`endif
    advance(3);
    applyStimulus(8'h01, 8'h00);
    advance(10);
    applyStimulus(8'h01, 8'h08);
    expect_at(1, SEL_RP, 8'h00, "clear3 rise");
    expect_at(1, SEL_FP, 8'h00, "clear3 fall");
    expect_at(1, SEL_IRQ, 8'h00, "clear3 irq");
    advance(2);

    // Clear colliding with a new rising edge on pin 1.
    rise_en = 8'h02; fall_en = 8'h00;
    applyStimulus(8'h03, 8'h00);
    expect_at(LAT + 1, SEL_RP, 8'h02, "pin1 first rise");
    advance(LAT + 3);
    applyStimulus(8'h01, 8'h00);
    advance(LAT + 3);
    applyStimulus(8'h03, 8'h00);
    expect_at(LAT, SEL_IV, 8'h03, "pin1 second in_value");
    advance(LAT);
    applyStimulus(8'h03, 8'h02);
    expect_at(1, SEL_RP, 8'h02, "collision set wins");
    expect_at(1, SEL_IRQ, 8'h01, "collision irq");
    advance(3);
    applyStimulus(8'h03, 8'h02);
    expect_at(1, SEL_RP, 8'h00, "lone clear1");
    expect_at(1, SEL_IRQ, 8'h00, "lone clear1 irq");
    advance(2);

    // Pin 2 toggles 1->0->1 with only rising edges enabled.
    rise_en = 8'h04; fall_en = 8'h00;
    applyStimulus(8'h07, 8'h00);
    expect_at(LAT + 1, SEL_RP, 8'h04, "pin2 rise");
    advance(LAT + 3);
    applyStimulus(8'h07, 8'h04);
    expect_at(1, SEL_RP, 8'h00, "pin2 clear");
    advance(2);
    applyStimulus(8'h03, 8'h00);
    expect_at(LAT + 2, SEL_FP, 8'h00, "pin2 fall disabled");
    expect_at(LAT + 2, SEL_RP, 8'h00, "pin2 no rise on fall");
    advance(LAT + 3);
    applyStimulus(8'h07, 8'h00);
    expect_at(LAT + 1, SEL_RP, 8'h04, "pin2 second rise");
    expect_at(LAT + 1, SEL_FP, 8'h00, "pin2 still no fall");
    advance(LAT + 3);
    rise_en = 8'h00;
    advance(3);
    expect_at(0, SEL_RP, 8'h04, "pin2 sticky after disable");
    advance(2);

    // Simultaneous edges on pins 4..7.
    rise_en = 8'hF0;
    applyStimulus(8'hF7, 8'h00);
    expect_at(LAT, SEL_RP, 8'h04, "multi before");
    expect_at(LAT, SEL_IV, 8'hF7, "multi in_value");
    expect_at(LAT + 1, SEL_RP, 8'hF4, "multi rise");
    advance(LAT + 3);

    for (int k = 0; k < 20 && sb.size() > 0; k++) advance(1);
    if (sb.size() > 0) begin
      errors += sb.size();
      $display("[TB] FAIL drain: got %0d pending expectations expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
